arb_spec_monitor_n: RTL and testbench
=====================================

Name: arb_spec_monitor_n

Overview:
- Parametrised successor to the fixed three-client arbiter spec monitor: one safety/fairness checker for an N-client arbiter with a controllable master select.
- Registers the previous cycle's ready/grant and checks grant/master consistency.
- Tracks bounded-response fairness per round, gated on environment fairness.
- Drives a single error output for synthesis/model-checking benches, plus per-cause flags and an optional sticky mode.

Parameters:
- N_CLIENTS, 3, number of requesters; must be at least 2.
- MW, $clog2(N_CLIENTS), width of controllable_master.
- FAIR_BOUND, 4, number of collect cycles allowed per round before fairness error.
- ENV_REARM, 0: 0 = environment fairness latched once, forever; 1 = re-await i_ready after every completed round.
- STICKY, 0: 1 = o_err stays high from the first error until reset.
- CHECK_ONEHOT, 0: 1 = additionally flag more than one controllable_grant bit set.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_ready  in  1  environment ready; also the environment fairness event.
- i_req  in  N_CLIENTS  per-client request.
- controllable_grant  in  N_CLIENTS  per-client grant from the controller.
- controllable_master  in  MW  selected master index.
- o_err  out  1  any error (combinational plus sticky term).
- o_err_safety  out  1  grant/master mismatch this cycle.
- o_err_fair  out  1  fairness counter has reached FAIR_BOUND.
- o_err_onehot  out  1  multiple grants this cycle; tied 0 when CHECK_ONEHOT=0.

Behaviour:
- Reset values: reg_ready=0, reg_grant=0, done[]=0, cnt=0, state=WAIT_ENV, err_q=0.
- Outputs after reset: o_err=0, o_err_fair=0, o_err_safety=0. o_err_onehot is combinational and follows controllable_grant even while in reset.
- Each edge: reg_ready <= i_ready and reg_grant <= controllable_grant.
- sel[i] = (controllable_master == i). A master value >= N_CLIENTS selects nobody.
- o_err_safety: combinational, = reg_ready & OR_i (reg_grant[i] XOR sel[i]). Zero latency relative to the master value.
- fair_now[i] = sel[i] | ~i_req[i].
- State machine, priority top-down:
  - alldone = AND done[]. If alldone: done <= 0, cnt <= 0, state <= (ENV_REARM ? WAIT_ENV : COLLECT).
  - Else, in WAIT_ENV: if i_ready then state <= COLLECT. done and cnt hold.
  - Else, in COLLECT: done[i] <= done[i] | fair_now[i], and cnt <= cnt+1, saturating at FAIR_BOUND (no wrap).
- The round clear takes one cycle after the last done bit sets. That cycle is not counted.
- cnt width is $clog2(FAIR_BOUND+1).
- o_err_fair = (cnt >= FAIR_BOUND). It stays high until a round completes.
- o_err_onehot = CHECK_ONEHOT & (popcount(controllable_grant) > 1).
- err_now = o_err_safety | o_err_fair | o_err_onehot.
- err_q <= err_q | err_now, only when STICKY=1.
- o_err = err_now | err_q.
- Reset asserted mid-round: all state clears asynchronously, and o_err drops in the same cycle, including the sticky term.
- Fairness and safety are independent: one cycle may raise both flags.

Decomposition:
- Shared package arb_spec_pkg:
  - state enum {WAIT_ENV, COLLECT};
  - function onehot_violation(vec);
  - function sat_inc(cnt, bound).
- One natural sub-module, arb_fair_tracker: state, done vector and saturating counter. Outputs alldone and fair_err.
- Safety, one-hot and error combining stay in the top module.

Test Plan:
- Reset, then i_ready=1; cycle1: controllable_grant=3'b010; cycle2: master=1 -> o_err_safety=0. Same sequence with master=0 in cycle2 -> o_err_safety=1 and o_err=1 in that cycle.
- i_ready=1 once; i_req=3'b111; master cycles 0,1,2 on consecutive collect cycles -> alldone after cycle 3, cnt clears on cycle 4, o_err_fair never 1.
- i_ready=1 once; i_req=3'b001 held; master=1 for 4 collect cycles -> cnt=4, o_err_fair=1; then master=0 -> round completes, next edge cnt=0 and o_err_fair=0.
- Environment-fairness gating:
  - i_ready=0 forever, i_req=3'b111, master never 2 -> state stays WAIT_ENV, cnt=0, no fairness error.
  - ENV_REARM=1: after one completed round with i_ready=0, cnt stays 0.
- STICKY=1: force one safety mismatch cycle, then legal traffic -> o_err stays 1. Assert i_rst mid-cycle -> o_err=0 immediately.
- CHECK_ONEHOT=1: controllable_grant=3'b011 -> o_err_onehot=1 and o_err=1 the same cycle. master=3 with N_CLIENTS=3 and reg_grant=0, reg_ready=1 -> o_err_safety=0.

Source files
------------

// File: rtl/arb_spec_pkg.sv
// Shared types and helpers for the N-client arbiter spec monitor.
package arb_spec_pkg;

    // Widest grant vector the helper functions accept (N_CLIENTS must not exceed it).
    localparam int unsigned MAX_CLIENTS = 64;

    // Fairness round phases: wait for the environment, then collect serviced clients.
    typedef enum logic {
        WAIT_ENV = 1'b0,
        COLLECT  = 1'b1
    } arb_state_e;

    // True when more than one bit of vec is set (clearing the lowest set bit leaves something).
    function automatic logic onehot_violation(input logic [MAX_CLIENTS-1:0] vec);
        return (vec & (vec - MAX_CLIENTS'(1))) != '0;
    endfunction

    // Increment that sticks at bound instead of wrapping.
    function automatic int unsigned sat_inc(input int unsigned cnt, input int unsigned bound);
        return (cnt >= bound) ? bound : cnt + 1;
    endfunction

endpackage

// File: rtl/arb_fair_tracker.sv
// Bounded-response fairness tracker: per-round done vector and saturating
// collect-cycle counter, gated on the environment fairness event.
module arb_fair_tracker
    import arb_spec_pkg::*;
#(
    parameter int unsigned N_CLIENTS  = 3,
    parameter int unsigned FAIR_BOUND = 4,
    parameter int unsigned ENV_REARM  = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ready,
    input  logic [N_CLIENTS-1:0] i_fair_now,
    output logic                 o_alldone,
    output logic                 o_fair_err
);

    localparam int unsigned    CW      = $clog2(FAIR_BOUND + 1);
    localparam logic [CW-1:0]  BOUND_C = CW'(FAIR_BOUND);

    arb_state_e           state_q, state_d;
    logic [N_CLIENTS-1:0] done_q,  done_d;
    logic [CW-1:0]        cnt_q,   cnt_d;

    // A round is complete once every client has been served or was idle.
    assign o_alldone  = &done_q;
    assign o_fair_err = (cnt_q >= BOUND_C);

    // Round state register; everything clears asynchronously on reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= WAIT_ENV;
            done_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    // Round clear has priority; the clearing cycle itself is not counted.
    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        if (o_alldone) begin
            done_d  = '0;
            cnt_d   = '0;
            state_d = (ENV_REARM != 0) ? WAIT_ENV : COLLECT;
        end else begin
            case (state_q)
                WAIT_ENV: begin
                    if (i_ready) begin
                        state_d = COLLECT;
                    end
                end
                COLLECT: begin
                    done_d = done_q | i_fair_now;
                    cnt_d  = CW'(sat_inc(32'(cnt_q), FAIR_BOUND));
                end
            endcase
        end
    end

endmodule

// File: rtl/arb_spec_monitor_n.sv
// Safety/fairness monitor for an N-client arbiter with a controllable master
// select. Safety compares last cycle's grant against the current master,
// fairness is delegated to the round tracker, and all causes feed one error.
module arb_spec_monitor_n
    import arb_spec_pkg::*;
#(
    parameter int unsigned N_CLIENTS    = 3,
    parameter int unsigned MW           = $clog2(N_CLIENTS),
    parameter int unsigned FAIR_BOUND   = 4,
    parameter int unsigned ENV_REARM    = 0,
    parameter int unsigned STICKY       = 0,
    parameter int unsigned CHECK_ONEHOT = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ready,
    input  logic [N_CLIENTS-1:0] i_req,
    input  logic [N_CLIENTS-1:0] controllable_grant,
    input  logic [MW-1:0]        controllable_master,
    output logic                 o_err,
    output logic                 o_err_safety,
    output logic                 o_err_fair,
    output logic                 o_err_onehot
);

    logic                 reg_ready_q, reg_ready_d;
    logic [N_CLIENTS-1:0] reg_grant_q, reg_grant_d;
    logic                 err_q,       err_d;
    logic [N_CLIENTS-1:0] sel;
    logic [N_CLIENTS-1:0] fair_now;
    logic                 err_now;
    // Round-complete strobe from the tracker; only the fairness flag is consumed here.
    logic                 unused_alldone;

    // Decode the master index; values at or above N_CLIENTS select no client.
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < N_CLIENTS; i++) begin
            sel[i] = (32'(controllable_master) == i);
        end
    end

    // A client is treated fairly this cycle if it is selected or not asking.
    assign fair_now = sel | ~i_req;

    arb_fair_tracker #(
        .N_CLIENTS  (N_CLIENTS),
        .FAIR_BOUND (FAIR_BOUND),
        .ENV_REARM  (ENV_REARM)
    ) u_fair (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_ready    (i_ready),
        .i_fair_now (fair_now),
        .o_alldone  (unused_alldone),
        .o_fair_err (o_err_fair)
    );

    assign o_err_safety = reg_ready_q & (|(reg_grant_q ^ sel));
    assign o_err_onehot = (CHECK_ONEHOT != 0) && onehot_violation(MAX_CLIENTS'(controllable_grant));
    assign err_now      = o_err_safety | o_err_fair | o_err_onehot;
    assign o_err        = err_now | err_q;

    // Next values for the registered ready/grant and the optional sticky error.
    always_comb begin
        reg_ready_d = i_ready;
        reg_grant_d = controllable_grant;
        err_d       = (STICKY != 0) ? (err_q | err_now) : 1'b0;
    end

    // Previous-cycle ready/grant and sticky error; reset drops them immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            reg_ready_q <= 1'b0;
            reg_grant_q <= '0;
            err_q       <= 1'b0;
        end else begin
            reg_ready_q <= reg_ready_d;
            reg_grant_q <= reg_grant_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_arb_spec_monitor_n.sv
// Bench for arb_spec_monitor_n: a default instance and one with ENV_REARM,
// STICKY and CHECK_ONEHOT enabled share the same stimulus; a reference model
// pushes expected outputs per cycle and a negedge monitor pops and compares.
module tb_arb_spec_monitor_n;

    logic       clk;
    logic       rst;
    logic       ready;
    logic [2:0] req;
    logic [2:0] grant;
    logic [1:0] master;

    logic a_err, a_saf, a_fair, a_oh;
    logic b_err, b_saf, b_fair, b_oh;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic [3:0] exp_a;
        logic [3:0] exp_b;
    } sb_entry_t;

    sb_entry_t sb[$];
    sb_entry_t cur;

    // Reference model state, index 0 = default instance, 1 = rearm/sticky/onehot.
    logic       m_rr[2];
    logic [2:0] m_rg[2];
    logic [2:0] m_done[2];
    int         m_cnt[2];
    logic       m_collect[2];
    logic       m_eq[2];

    arb_spec_monitor_n dut_a (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_ready             (ready),
        .i_req               (req),
        .controllable_grant  (grant),
        .controllable_master (master),
        .o_err               (a_err),
        .o_err_safety        (a_saf),
        .o_err_fair          (a_fair),
        .o_err_onehot        (a_oh)
    );

    arb_spec_monitor_n #(
        .ENV_REARM    (1),
        .STICKY       (1),
        .CHECK_ONEHOT (1)
    ) dut_b (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_ready             (ready),
        .i_req               (req),
        .controllable_grant  (grant),
        .controllable_master (master),
        .o_err               (b_err),
        .o_err_safety        (b_saf),
        .o_err_fair          (b_fair),
        .o_err_onehot        (b_oh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] model_sel(input logic [1:0] m);
        logic [2:0] s;
        s = 3'b000;
        if (m < 2'd3) s[m] = 1'b1;
        return s;
    endfunction

    // Expected {o_err, o_err_safety, o_err_fair, o_err_onehot} for the current inputs.
    function automatic logic [3:0] model_out(input int k);
        logic [2:0] s;
        logic saf, fair, oh;
        s    = model_sel(master);
        saf  = m_rr[k] & (|(m_rg[k] ^ s));
        fair = (m_cnt[k] >= 4);
        oh   = (k == 1) && ($countones(grant) > 1);
        return {saf | fair | oh | m_eq[k], saf, fair, oh};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_rr[k] = 1'b0; m_rg[k] = 3'b000; m_done[k] = 3'b000;
            m_cnt[k] = 0; m_collect[k] = 1'b0; m_eq[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic [3:0] o;
            logic [2:0] fn;
            o  = model_out(k);
            fn = model_sel(master) | ~req;
            if (m_done[k] == 3'b111) begin
                m_done[k] = 3'b000;
                m_cnt[k]  = 0;
                m_collect[k] = (k == 0);
            end else if (!m_collect[k]) begin
                if (ready) m_collect[k] = 1'b1;
            end else begin
                m_done[k] = m_done[k] | fn;
                if (m_cnt[k] < 4) m_cnt[k] = m_cnt[k] + 1;
            end
            m_eq[k] = (k == 1) ? (m_eq[k] | (|o[2:0])) : 1'b0;
            m_rr[k] = ready;
            m_rg[k] = grant;
        end
    endtask

    task automatic drive(input string tag, input logic r, input logic [2:0] rq,
                         input logic [2:0] gt, input logic [1:0] ms);
        sb_entry_t e;
        ready = r; req = rq; grant = gt; master = ms;
        e.tag   = tag;
        e.exp_a = model_out(0);
        e.exp_b = model_out(1);
        sb.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset(input logic [2:0] gt);
        logic oh;
        rst = 1'b1; ready = 1'b0; req = 3'b000; grant = gt; master = 2'd0;
        model_reset();
        oh = ($countones(gt) > 1);
        #1;
        check_val("rst_saf_a",  32'(a_saf),  0);
        check_val("rst_fair_a", 32'(a_fair), 0);
        check_val("rst_err_a",  32'(a_err),  0);
        check_val("rst_oh_a",   32'(a_oh),   0);
        check_val("rst_saf_b",  32'(b_saf),  0);
        check_val("rst_fair_b", 32'(b_fair), 0);
        check_val("rst_oh_b",   32'(b_oh),   32'(oh));
        check_val("rst_err_b",  32'(b_err),  32'(oh));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0; grant = 3'b000;
    endtask

    // Scoreboard consumer: compare every pushed expectation away from the active edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            check_val({cur.tag, "_a"}, {28'd0, a_err, a_saf, a_fair, a_oh}, {28'd0, cur.exp_a});
            check_val({cur.tag, "_b"}, {28'd0, b_err, b_saf, b_fair, b_oh}, {28'd0, cur.exp_b});
        end
    end

    initial begin
        // Safety: grant 010 then master 1 is legal
        do_reset(3'b000);
        drive("safe1", 1'b1, 3'b000, 3'b010, 2'd0); tick();
        drive("safe2", 1'b0, 3'b000, 3'b000, 2'd1);
        #1; check_val("tp_safe_ok", 32'(a_saf), 0);
        tick();

        // Safety: grant 010 then master 0 is a mismatch; then sticky hold and mid-cycle reset
        do_reset(3'b000);
        drive("bad1", 1'b1, 3'b000, 3'b010, 2'd0); tick();
        drive("bad2", 1'b0, 3'b000, 3'b000, 2'd0);
        #1;
        check_val("tp_safe_bad_a", 32'(a_saf), 1);
        check_val("tp_err_bad_a",  32'(a_err), 1);
        check_val("tp_safe_bad_b", 32'(b_saf), 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive("legal", 1'b0, 3'b000, 3'b000, 2'd0);
            #1;
            check_val("nonsticky_err", 32'(a_err), 0);
            check_val("sticky_err",    32'(b_err), 1);
            tick();
        end
        #2; rst = 1'b1; #1;
        check_val("midrst_err_b", 32'(b_err), 0);
        check_val("midrst_err_a", 32'(a_err), 0);
        model_reset();
        @(posedge clk); #1; rst = 1'b0;

        // Full round 0,1,2 with all requesting; then rearm gating vs. permanent env latch
        do_reset(3'b000);
        drive("rnd_env", 1'b1, 3'b111, 3'b000, 2'd3); tick();
        for (int m = 0; m < 4; m++) begin
            drive("rnd", 1'b0, 3'b111, 3'b000, 2'(m % 3));
            #1; check_val("rnd_fair", 32'(a_fair), 0);
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            drive("rearm", 1'b0, 3'b111, 3'b000, 2'd0);
            #1;
            check_val("rearm_fair_b", 32'(b_fair), 0);
            check_val("latch_fair_a", 32'(a_fair), 32'(i >= 4));
            tick();
        end

        // Starved client 0: counter saturates, round completes, flag drops after clear
        do_reset(3'b000);
        drive("st_env", 1'b1, 3'b001, 3'b000, 2'd3); tick();
        for (int i = 0; i < 10; i++) begin
            drive("starve", 1'b0, 3'b001, 3'b000, 2'd1);
            #1; check_val("starve_fair", 32'(a_fair), 32'(i >= 4));
            tick();
        end
        drive("serve", 1'b0, 3'b001, 3'b000, 2'd0);
        #1; check_val("serve_fair", 32'(a_fair), 1);
        tick();
        drive("clear", 1'b0, 3'b001, 3'b000, 2'd0);
        #1; check_val("clear_fair", 32'(a_fair), 1);
        tick();
        drive("after", 1'b0, 3'b001, 3'b000, 2'd0);
        #1; check_val("after_fair", 32'(a_fair), 0);
        tick();

        // No environment fairness: never leaves WAIT_ENV
        do_reset(3'b000);
        for (int i = 0; i < 8; i++) begin
            drive("noenv", 1'b0, 3'b111, 3'b000, 2'(i % 2));
            #1; check_val("noenv_fair", 32'(a_fair), 0);
            tick();
        end

        // One-hot: visible during reset, same-cycle error, and out-of-range master
        do_reset(3'b011);
        drive("oh1", 1'b1, 3'b000, 3'b011, 2'd0);
        #1;
        check_val("oh_flag_b", 32'(b_oh),  1);
        check_val("oh_err_b",  32'(b_err), 1);
        check_val("oh_flag_a", 32'(a_oh),  0);
        tick();
        drive("oh2", 1'b1, 3'b000, 3'b000, 2'd3); tick();
        drive("m3", 1'b0, 3'b000, 3'b000, 2'd3);
        #1;
        check_val("m3_saf_a", 32'(a_saf), 0);
        check_val("m3_saf_b", 32'(b_saf), 0);
        tick();

        @(negedge clk); #1;
        check_val("sb_drain", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
